sram_port_scheduler: RTL and testbench
======================================

// Module: sram_port_scheduler
// PURPOSE
// - Shares one 48-bit external SRAM word between three users: the CPU data port (lanes [31:0]),
//   the video write port (lanes [47:32]) and the VGA scan-out reader.
// - Each partial-lane write is sequenced as a read-modify-write, so the other user's lanes survive.
// - Sits between the CPU/VRAM bus masters and the SRAM pad wrapper. Tristate is handled in that wrapper.
// PARAMETERS
// - ADDR_W   20  SRAM word address width
// - DATA_W   48  SRAM word width
// - CPU_W    32  CPU lane width, bits [CPU_W-1:0]
// - VID_W    16  video lane width, bits [DATA_W-1:DATA_W-VID_W]
// - SCAN_EN  1   1: odd cycles are reserved for scan-out; 0: every cycle is an access slot
// PORTS
// - clk_50mhz        in   1       single clock; all state changes on its rising edge
// - rst              in   1       synchronous, active-high reset
// - hold             in   1       1: no new grants (used by the init copier); an op already in flight completes
// - cpu_stb/cpu_we   in   1/1     CPU request and write enable
// - cpu_addr         in   ADDR_W  CPU word address
// - cpu_din          in   CPU_W   CPU write data
// - cpu_dout         out  CPU_W   CPU read data, valid while cpu_ack=1
// - cpu_ack          out  1       one-cycle completion pulse
// - vid_stb/vid_we   in   1/1     video request and write enable
// - vid_addr         in   ADDR_W   video word address
// - vid_din          in   VID_W    video write data
// - vid_dout         out  VID_W    video read data, valid while vid_ack=1
// - vid_ack          out  1       one-cycle completion pulse
// - vram_scan_addr   in   ADDR_W  scan-out word address
// - vram_scan_data   out  VID_W   registered scan pixel word
// - sram_addr        out  ADDR_W  SRAM address
// - sram_we          out  1       SRAM write strobe, active high
// - sram_wdata       out  DATA_W  SRAM write word
// - sram_rdata       in   DATA_W  SRAM read word; combinational from sram_addr in the same cycle
// - busy             out  1       FSM not IDLE
// BEHAVIOUR
// - Slot register scan_slot: reset 0, toggles every cycle (tied to 0 when SCAN_EN=0).
//   - Cycle with scan_slot=1: sram_addr=vram_scan_addr, sram_we=0. At the edge ending the cycle,
//     vram_scan_data <= sram_rdata[47:32].
//   - Cycle with scan_slot=0 is an access slot. The FSM advances only on the edges that end access slots.
// - FSM states: IDLE, READ, WRITE.
//   - IDLE: if !hold and a stb is high, grant that requester. Latch addr, we, din and the grant id; go to READ.
//   - Tie between CPU and video: round-robin on last_grant (reset = video, so the CPU wins the first tie).
//   - READ: sram_addr=latched addr. At slot end, rd_buf <= sram_rdata.
//     - Read op: pulse ack and go to IDLE.
//     - Write op: go to WRITE.
//   - WRITE: sram_addr=latched addr, sram_we=1.
//     - sram_wdata = CPU ? {rd_buf[47:32], din32} : {din16, rd_buf[31:0]}.
//     - At slot end, pulse ack and go to IDLE.
// - Timing: let t be the access cycle at whose end a request is granted.
//   - Read: ack high in cycle t+3. Write: sram_we high only in cycle t+4; ack high in cycle t+5.
//   - With SCAN_EN=0: read ack in cycle t+2, write ack in cycle t+3.
// - Read data: cpu_dout=rd_buf[31:0] and vid_dout=rd_buf[47:32], held until the next READ capture.
// - Requester rules:
//   - Hold stb and operands until ack; drop stb by the cycle after ack, or the request is re-granted.
//   - Operands are latched at grant. If stb drops mid-op, the op still completes and ack still pulses.
// - sram_we = (state==WRITE) & ~scan_slot & ~rst. It is never 1 in a scan slot or in a reset cycle.
// - Outside READ/WRITE access slots, sram_addr = latched addr and sram_wdata = 0.
// - Reset values: state IDLE, scan_slot 0, cpu_ack/vid_ack 0, rd_buf 0, vram_scan_data 0, busy 0,
//   last_grant video.
// - Reset mid-op: the op is abandoned, no ack is issued and the SRAM word is unmodified.
// STRUCTURE
// - sram_sched_defs.vh: state encodings, CPU_LO/CPU_HI and VID_LO/VID_HI lane localparams, GRANT_CPU/GRANT_VID.
// - One sub-module, rr_arb2: 2-way round-robin arbiter (req[1:0], advance, gnt[1:0], last-grant register).
// - Lane merge and output muxing stay inline.
// TESTING
// - CPU read 0x00010, model word 0x1234_89ABCDEF -> cpu_ack in cycle t+3, cpu_dout=0x89ABCDEF, sram_we never 1.
// - Video write 0x00020 din 0xBEEF over word 0x1111_22223333 -> one sram_we cycle, word becomes 0xBEEF_22223333.
// - CPU write 0x00020 din 0xDEADBEEF over word 0xBEEF_22223333 -> word becomes 0xBEEF_DEADBEEF.
// - Both stb high continuously -> grant order CPU, VID, CPU, VID, ...; exactly one ack per op.
// - Scan 0x00040 holding 0xCAFE_00000000 during back-to-back writes -> vram_scan_data=0xCAFE; sram_we=0 in scan slots.
// - rst asserted in the WRITE cycle -> sram_we=0, no ack, word unchanged.
// - hold=1 with cpu_stb high -> no grant; hold falls -> grant at the next access edge.

Source files
------------

// File: rtl/sram_port_scheduler_pkg.sv
// Shared types and constants for the SRAM port scheduler.
// Requester ids are used both by the arbiter and by the top-level lane merge.
package sram_port_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_VID = 1'b1;

endpackage

// File: rtl/sram_port_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: req[0] = CPU, req[1] = video.
// On a tie the requester that did not win last time is chosen.
module sram_port_scheduler_rr_arb2
  import sram_port_scheduler_pkg::*;
(
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      gnt = (last_q == GRANT_VID) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    last_d = last_q;
    if (advance && (|req)) begin
      last_d = gnt[1] ? GRANT_VID : GRANT_CPU;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      last_q <= GRANT_VID;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_port_scheduler.sv
// Shares one SRAM word between the CPU lanes, the video lanes and VGA scan-out.
// Partial-lane writes are read-modify-write so the other requester's lanes survive.
module sram_port_scheduler
  import sram_port_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 48,
  parameter int unsigned CPU_W   = 32,
  parameter int unsigned VID_W   = 16,
  parameter bit          SCAN_EN = 1'b1
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              hold,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [CPU_W-1:0]  cpu_din,
  output logic [CPU_W-1:0]  cpu_dout,
  output logic              cpu_ack,
  input  logic              vid_stb,
  input  logic              vid_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [VID_W-1:0]  vid_din,
  output logic [VID_W-1:0]  vid_dout,
  output logic              vid_ack,
  input  logic [ADDR_W-1:0] vram_scan_addr,
  output logic [VID_W-1:0]  vram_scan_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              scan_slot_q, scan_slot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              gid_q, gid_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic [VID_W-1:0]  scan_data_q, scan_data_d;
  logic [1:0]        req, gnt;
  logic              grant_en;
  logic [DATA_W-1:0] merged;

  // A requester whose ack is still showing is masked so it is not re-granted on the same word.
  assign req      = {vid_stb & ~vid_ack_q, cpu_stb & ~cpu_ack_q};
  assign grant_en = ~scan_slot_q & (state_q == StIdle) & ~hold & (|req);

  sram_port_scheduler_rr_arb2 u_arb (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .req       (req),
    .advance   (grant_en),
    .gnt       (gnt)
  );

  always_comb begin
    state_d     = state_q;
    scan_slot_d = SCAN_EN ? ~scan_slot_q : 1'b0;
    addr_d      = addr_q;
    we_d        = we_q;
    gid_d       = gid_q;
    din_d       = din_q;
    rd_buf_d    = rd_buf_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    scan_data_d = scan_data_q;
    if (scan_slot_q) begin
      scan_data_d = sram_rdata[DATA_W-1:DATA_W-VID_W];
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            state_d = StRead;
            if (gnt[1]) begin
              gid_d  = GRANT_VID;
              addr_d = vid_addr;
              we_d   = vid_we;
              din_d  = {vid_din, {(DATA_W-VID_W){1'b0}}};
            end else begin
              gid_d  = GRANT_CPU;
              addr_d = cpu_addr;
              we_d   = cpu_we;
              din_d  = {{(DATA_W-CPU_W){1'b0}}, cpu_din};
            end
          end
        end
        StRead: begin
          rd_buf_d = sram_rdata;
          if (we_q) begin
            state_d = StWrite;
          end else begin
            state_d   = StIdle;
            cpu_ack_d = (gid_q == GRANT_CPU);
            vid_ack_d = (gid_q == GRANT_VID);
          end
        end
        StWrite: begin
          state_d   = StIdle;
          cpu_ack_d = (gid_q == GRANT_CPU);
          vid_ack_d = (gid_q == GRANT_VID);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q     <= StIdle;
      scan_slot_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      gid_q       <= GRANT_CPU;
      din_q       <= '0;
      rd_buf_q    <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      scan_data_q <= '0;
    end else begin
      state_q     <= state_d;
      scan_slot_q <= scan_slot_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      gid_q       <= gid_d;
      din_q       <= din_d;
      rd_buf_q    <= rd_buf_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      scan_data_q <= scan_data_d;
    end
  end

  // Keep the other requester's lanes from the word captured in READ.
  assign merged = (gid_q == GRANT_CPU) ?
                  {rd_buf_q[DATA_W-1:CPU_W], din_q[CPU_W-1:0]} :
                  {din_q[DATA_W-1:DATA_W-VID_W], rd_buf_q[DATA_W-VID_W-1:0]};

  assign sram_addr      = scan_slot_q ? vram_scan_addr : addr_q;
  assign sram_we        = (state_q == StWrite) & ~scan_slot_q & ~rst;
  assign sram_wdata     = ((state_q == StWrite) && !scan_slot_q) ? merged : '0;
  assign cpu_dout       = rd_buf_q[CPU_W-1:0];
  assign vid_dout       = rd_buf_q[DATA_W-1:DATA_W-VID_W];
  assign cpu_ack        = cpu_ack_q;
  assign vid_ack        = vid_ack_q;
  assign vram_scan_data = scan_data_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_sram_port_scheduler.sv
// Directed bench for sram_port_scheduler with a small behavioural SRAM model.
// Expected values are hand-computed from the word contents preloaded below.
module tb_sram_port_scheduler;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        cpu_stb, cpu_we, vid_stb, vid_we;
  logic [19:0] cpu_addr, vid_addr, vram_scan_addr, sram_addr;
  logic [31:0] cpu_din, cpu_dout;
  logic [15:0] vid_din, vid_dout, vram_scan_data;
  logic        cpu_ack, vid_ack, sram_we, busy;
  logic [47:0] sram_wdata, sram_rdata;

  logic [47:0] mem [0:255];
  logic        tb_slot;
  int          scan_bad = 0;
  int          hi_bad   = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  sram_port_scheduler dut (
    .clk_50mhz      (clk),
    .rst            (rst),
    .hold           (hold),
    .cpu_stb        (cpu_stb),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .cpu_ack        (cpu_ack),
    .vid_stb        (vid_stb),
    .vid_we         (vid_we),
    .vid_addr       (vid_addr),
    .vid_din        (vid_din),
    .vid_dout       (vid_dout),
    .vid_ack        (vid_ack),
    .vram_scan_addr (vram_scan_addr),
    .vram_scan_data (vram_scan_data),
    .sram_addr      (sram_addr),
    .sram_we        (sram_we),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .busy           (busy)
  );

  assign sram_rdata = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
    tb_slot <= rst ? 1'b0 : ~tb_slot;
  end

  // Independent slot model: odd cycles after reset must present the scan address, never a write.
  always @(negedge clk) begin
    if (!rst) begin
      if (tb_slot && (sram_we || sram_addr != vram_scan_addr)) scan_bad++;
      if (sram_addr[19:8] != 12'h0) hi_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and measures latencies relative to t (the cycle before busy first rises).
  task automatic do_op(input bit is_cpu, input bit we, input logic [19:0] addr,
                       input logic [31:0] din, output int lat_ack, output int lat_we,
                       output int n_we, output logic [31:0] rdata);
    int b, a, w;
    b = -1; a = -1; w = -1; n_we = 0; rdata = '0;
    if (is_cpu) begin
      cpu_stb = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    end else begin
      vid_stb = 1'b1; vid_we = we; vid_addr = addr; vid_din = din[15:0];
    end
    for (int k = 1; k <= 40 && a < 0; k++) begin
      tick();
      if (busy && b < 0) b = k;
      if (sram_we) begin
        n_we++;
        if (w < 0) w = k;
      end
      if (is_cpu ? cpu_ack : vid_ack) begin
        a = k;
        rdata = is_cpu ? cpu_dout : {16'h0, vid_dout};
      end
    end
    cpu_stb = 1'b0;
    vid_stb = 1'b0;
    lat_ack = (a < 0 || b < 0) ? -1 : a - (b - 1);
    lat_we  = (w < 0 || b < 0) ? -1 : w - (b - 1);
  endtask

  initial begin
    int          la, lw, nw, seen, acks, grants, dual, exp_lat, k;
    logic        busy_prev;
    logic [31:0] rd;

    rst = 1'b1; hold = 1'b0;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_stb = 1'b0; vid_we = 1'b0; vid_addr = '0; vid_din = '0;
    vram_scan_addr = 20'h00040;
    for (int i = 0; i < 256; i++) mem[i] <= 48'h0;
    mem[8'h10] <= 48'h1234_89AB_CDEF;
    mem[8'h20] <= 48'h1111_2222_3333;
    mem[8'h30] <= 48'h5555_6666_7777;
    mem[8'h40] <= 48'hCAFE_0000_0000;
    repeat (4) tick();

    check_eq("rst_busy", busy, 0);
    check_eq("rst_cpu_ack", cpu_ack, 0);
    check_eq("rst_vid_ack", vid_ack, 0);
    check_eq("rst_scan_data", vram_scan_data, 0);
    check_eq("rst_cpu_dout", cpu_dout, 0);
    check_eq("rst_sram_we", sram_we, 0);
    rst = 1'b0;

    do_op(1'b1, 1'b0, 20'h00010, 32'h0, la, lw, nw, rd);
    check_eq("cpu_rd_ack_lat", la, 3);
    check_eq("cpu_rd_dout", rd, 32'h89AB_CDEF);
    check_eq("cpu_rd_no_we", nw, 0);

    do_op(1'b0, 1'b1, 20'h00020, 32'h0000_BEEF, la, lw, nw, rd);
    check_eq("vid_wr_ack_lat", la, 5);
    check_eq("vid_wr_we_lat", lw, 4);
    check_eq("vid_wr_we_cnt", nw, 1);
    check_eq("vid_wr_word", mem[8'h20], 48'hBEEF_2222_3333);

    do_op(1'b1, 1'b1, 20'h00020, 32'hDEAD_BEEF, la, lw, nw, rd);
    check_eq("cpu_wr_ack_lat", la, 5);
    check_eq("cpu_wr_we_cnt", nw, 1);
    check_eq("cpu_wr_word", mem[8'h20], 48'hBEEF_DEAD_BEEF);
    check_eq("scan_data", vram_scan_data, 16'hCAFE);

    // Reset landing in the WRITE cycle must suppress the write and the ack.
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00030; cpu_din = 32'h0;
    seen = 0;
    for (k = 0; k < 20 && seen == 0; k++) begin
      tick();
      if (sram_we) seen = 1;
    end
    check_eq("rstw_reached", seen, 1);
    rst = 1'b1;
    cpu_stb = 1'b0;
    #1;
    check_eq("rstw_we_gated", sram_we, 0);
    tick();
    rst = 1'b0;
    acks = 0;
    repeat (8) begin
      tick();
      if (cpu_ack || vid_ack) acks++;
    end
    check_eq("rstw_no_ack", acks, 0);
    check_eq("rstw_word", mem[8'h30], 48'h5555_6666_7777);
    check_eq("rstw_busy", busy, 0);

    // hold blocks grants; release grants at the next access-slot edge.
    hold = 1'b1;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    seen = 0;
    repeat (6) begin
      tick();
      if (busy) seen = 1;
    end
    check_eq("hold_no_grant", seen, 0);
    hold = 1'b0;
    exp_lat = tb_slot ? 2 : 1;
    la = -1;
    for (k = 1; k <= 10 && la < 0; k++) begin
      tick();
      if (busy) la = k;
    end
    check_eq("hold_grant_lat", la, exp_lat);
    seen = 0;
    for (k = 0; k < 10 && seen == 0; k++) begin
      tick();
      if (cpu_ack) seen = 1;
    end
    cpu_stb = 1'b0;
    check_eq("hold_ack", seen, 1);
    check_eq("hold_dout", cpu_dout, 32'h89AB_CDEF);

    // Round-robin from a fresh reset: CPU wins the first tie, then strict alternation.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    vid_stb = 1'b1; vid_we = 1'b0; vid_addr = 20'h00020;
    acks = 0; grants = 0; dual = 0; busy_prev = 1'b0;
    for (k = 0; k < 30; k++) begin
      tick();
      if (k == 18) begin
        cpu_stb = 1'b0;
        vid_stb = 1'b0;
      end
      if (busy && !busy_prev) grants++;
      busy_prev = busy;
      if (cpu_ack && vid_ack) dual++;
      if (cpu_ack) begin
        check_eq("rr_order", 0, acks % 2);
        check_eq("rr_cpu_dout", cpu_dout, 32'h89AB_CDEF);
        acks++;
      end else if (vid_ack) begin
        check_eq("rr_order", 1, acks % 2);
        check_eq("rr_vid_dout", vid_dout, 16'hBEEF);
        acks++;
      end
    end
    check_eq("rr_enough_ops", acks >= 4, 1);
    check_eq("rr_ack_per_grant", acks, grants);
    check_eq("rr_no_dual_ack", dual, 0);
    check_eq("rr_idle_end", busy, 0);

    check_eq("scan_slot_clean", scan_bad, 0);
    check_eq("addr_hi_zero", hi_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
